// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared types for the bit-serial subtractor.
// Provides the FSM state type built from the encodings in serial_sub_defs.vh,
// and a helper that sizes the bit counter from the operand width.
package serial_subtractor_pkg;

`include "serial_sub_defs.vh"

  typedef enum logic [1:0] {
    IDLE  = `SSUB_IDLE,
    SHIFT = `SSUB_SHIFT,
    DONE  = `SSUB_DONE
  } state_t;

  // Smallest counter width that can hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_defs.vh
// serial_sub_defs.vh
// Shared FSM state encodings for the bit-serial subtractor.
// Pulled into serial_subtractor_pkg, so the RTL and the bench see one copy.
`ifndef SERIAL_SUB_DEFS_VH
`define SERIAL_SUB_DEFS_VH

`define SSUB_IDLE  2'd0
`define SSUB_SHIFT 2'd1
`define SSUB_DONE  2'd2

`endif

// File: rtl/serial_subtractor_cell.sv
// full_subtractor
// One-bit full subtractor cell: computes a - b - bin.
// Ports:
//   a, b    operand bits
//   bin     borrow in
//   diff    difference bit
//   borrow  borrow out
// Purely combinational.
module full_subtractor (
  output logic diff,
  output logic borrow,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first,
// one bit per clock through a single full_subtractor and a borrow flop.
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a subtraction (only looked at while idle)
//   a, b        minuend / subtrahend, captured on the accepting edge
//   diff        result, held until the next operation completes
//   borrow_out  final borrow (1 when a < b)
//   busy        high while bits are being processed
//   done        one-cycle pulse when diff/borrow_out are fresh
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Only WIDTH-1 partial bits need storing; the final bit joins them
  // directly on the last edge when diff is written.
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             bor;
  logic             d_bit, bor_nxt;
  logic             last;

  full_subtractor u_cell (
    .diff   (d_bit),
    .borrow (bor_nxt),
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .bin    (bor)
  );

  assign acc  = {d_bit, res};
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      cnt        <= '0;
      bor        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= a;
          b_sh <= b;
          bor  <= 1'b0;
          cnt  <= '0;
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bor  <= bor_nxt;
          res  <= acc[WIDTH-1:1];
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff       <= acc;
            borrow_out <= bor_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor (WIDTH=8) plus a standalone
// exhaustive sweep of the full_subtractor cell.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] diff;
  logic         borrow_out, busy, done;

  logic fs_a, fs_b, fs_bin, fs_diff, fs_borrow;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  full_subtractor u_fs (
    .diff   (fs_diff),
    .borrow (fs_borrow),
    .a      (fs_a),
    .b      (fs_b),
    .bin    (fs_bin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    int   r;
    r    = int'(x) - int'(y);
    m.d  = r[W-1:0];
    m.bo = (r < 0);
    return m;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow_out", 32'(borrow_out), 32'(e.bo));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag, input bit release_rst);
    int edges;
    int bsy;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    bsy   = 0;
    while (done !== 1'b1 && edges < 3 * W) begin
      if (busy === 1'b1) bsy++;
      @(negedge clk);
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(W + 1));
    chk({tag, "_busy_cycles"}, 32'(bsy), 32'(W));
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dc;
    int t;
    int prev_cyc;
    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    fs_a = 1'b0;
    fs_b = 1'b0;
    fs_bin = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // start present on the very first edge after reset release
    run_op(8'd5, 8'd3, "op_5_3", 1'b1);
    run_op(8'd3, 8'd5, "op_3_5", 1'b0);
    run_op(8'd0, 8'd0, "op_0_0", 1'b0);
    run_op(8'd255, 8'd255, "op_255_255", 1'b0);
    run_op(8'd0, 8'd1, "op_0_1", 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "op_rand", 1'b0);

    // start during SHIFT must be ignored
    dc = done_cnt;
    @(negedge clk);
    a = 8'd7;
    b = 8'd2;
    start = 1'b1;
    sb.push_back(model(8'd7, 8'd2));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3 * W) @(negedge clk);
    chk("ignore_done_count", 32'(done_cnt - dc), 32'd1);
    chk("ignore_diff_held", 32'(diff), 32'd5);
    chk("ignore_sb_empty", 32'(sb.size()), 32'd0);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'd20;
    b = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    dc = done_cnt;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    run_op(8'd10, 8'd1, "post_rst_10_1", 1'b1);

    // start held high: back-to-back operations
    pa[0] = 8'd100; pb[0] = 8'd37;
    pa[1] = 8'd17;  pb[1] = 8'd200;
    pa[2] = 8'd128; pb[2] = 8'd128;
    pa[3] = 8'd1;   pb[3] = 8'd255;
    @(negedge clk);
    a = pa[0];
    b = pb[0];
    start = 1'b1;
    sb.push_back(model(pa[0], pb[0]));
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (done !== 1'b1 && t < 40);
      if (t >= 40) chk("b2b_timeout", 32'd1, 32'd0);
      if (k > 0) chk("b2b_spacing", 32'(cyc - prev_cyc), 32'd10);
      prev_cyc = cyc;
      if (k < 3) begin
        a = pa[k+1];
        b = pb[k+1];
        sb.push_back(model(pa[k+1], pb[k+1]));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3 * W) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // full_subtractor truth table
    for (int i = 0; i < 8; i++) begin
      int r;
      logic [2:0] v;
      v = 3'(i);
      fs_a = v[2];
      fs_b = v[1];
      fs_bin = v[0];
      #1;
      r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
      chk("fs_diff", 32'(fs_diff), 32'(r & 1));
      chk("fs_borrow", 32'(fs_borrow), 32'(r < 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
